// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// State encoding, latency limits, grant codes and the latched access bundle.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_A    = 2'b01;
  localparam logic [1:0] GNT_B    = 2'b10;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } xfer_t;

  function automatic int clamp_lat(input int lat);
    if (lat < RD_LAT_MIN) return RD_LAT_MIN;
    if (lat > RD_LAT_MAX) return RD_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter.
// slave = arbiter view, master = requesters plus memory.
interface mem_arbiter_if;
  logic       a_req;
  logic       b_req;
  logic       a_we;
  logic       b_we;
  logic [7:0] a_addr;
  logic [7:0] b_addr;
  logic [7:0] a_wdata;
  logic [7:0] b_wdata;
  logic       a_ack;
  logic       b_ack;
  logic [7:0] a_rdata;
  logic [7:0] b_rdata;
  logic [7:0] mem_address;
  logic [7:0] mem_data_in;
  logic       mem_write;
  logic [7:0] mem_data_out;

  modport slave (
    input  a_req, b_req, a_we, b_we,
    input  a_addr, b_addr,
    input  a_wdata, b_wdata,
    input  mem_data_out,
    output a_ack, b_ack,
    output a_rdata, b_rdata,
    output mem_address, mem_data_in,
    output mem_write
  );

  modport master (
    output a_req, b_req, a_we, b_we,
    output a_addr, b_addr,
    output a_wdata, b_wdata,
    output mem_data_out,
    input  a_ack, b_ack,
    input  a_rdata, b_rdata,
    input  mem_address, mem_data_in,
    input  mem_write
  );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester grant decision: round-robin or fixed A-first.
// Produces a one-hot grant from the requests and the last winner.
module rr_arb2
  import mem_arbiter_pkg::*;
#(
  parameter int FAIR = 1
) (
  input  logic       a_req,
  input  logic       b_req,
  input  logic       last_b,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = GNT_NONE;
    unique case (1'b1)
      (a_req && b_req):
        gnt = ((FAIR != 0) && !last_b)
            ? GNT_B : GNT_A;
      (a_req && !b_req):
        gnt = GNT_A;
      (!a_req && b_req):
        gnt = GNT_B;
      default:
        gnt = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates requesters A and B onto one synchronous memory port.
// One access at a time: IDLE -> ADDR -> (WAIT) -> DONE -> IDLE.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int FAIR       = 1
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int LAT = clamp_lat(RD_LATENCY);
  localparam logic [1:0] LAST = 2'(LAT - 1);

  state_t     state;
  state_t     state_n;
  xfer_t      xfer;
  xfer_t      pick;
  logic [1:0] gnt;
  logic       win_b;
  logic       last_b;
  logic [1:0] cnt;
  logic       rd_done;
  logic [7:0] a_rdata;
  logic [7:0] b_rdata;

  rr_arb2 #(
    .FAIR(FAIR)
  ) u_arb (
    .a_req (bus.a_req),
    .b_req (bus.b_req),
    .last_b(last_b),
    .gnt   (gnt)
  );

  always_comb begin
    pick = '0;
    if (gnt[1]) begin
      pick = {bus.b_we, bus.b_addr, bus.b_wdata};
    end else begin
      pick = {bus.a_we, bus.a_addr, bus.a_wdata};
    end
  end

  assign rd_done = (state == WAIT) && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      xfer    <= '0;
      win_b   <= 1'b0;
      last_b  <= 1'b1;
      cnt     <= 2'd0;
      a_rdata <= 8'h00;
      b_rdata <= 8'h00;
    end else begin
      state <= state_n;
      if ((state == IDLE) && (gnt != GNT_NONE)) begin
        xfer   <= pick;
        win_b  <= gnt[1];
        last_b <= gnt[1];
      end
      if (state == WAIT) begin
        cnt <= cnt + 2'd1;
      end else begin
        cnt <= 2'd0;
      end
      // Read data lands in the winner's register on the WAIT->DONE edge
      if (rd_done && win_b) begin
        b_rdata <= bus.mem_data_out;
      end
      if (rd_done && !win_b) begin
        a_rdata <= bus.mem_data_out;
      end
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (gnt != GNT_NONE) state_n = ADDR;
      ADDR: state_n = xfer.we ? DONE : WAIT;
      WAIT: if (rd_done) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.mem_address = xfer.addr;
  assign bus.mem_data_in = xfer.wdata;
  assign bus.mem_write   = (state == ADDR) && xfer.we;
  assign bus.a_ack       = (state == DONE) && !win_b;
  assign bus.b_ack       = (state == DONE) && win_b;
  assign bus.a_rdata     = a_rdata;
  assign bus.b_rdata     = b_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: FAIR=1/RD_LATENCY=1 and FAIR=0/RD_LATENCY=2
// share one stimulus stream and are scored against a timing-level model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int L0 = 1;
  localparam int L1 = 2;
  localparam logic [7:0] ROM_TOP = 8'h40;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_if bus0 ();
  mem_arbiter_if bus1 ();

  mem_arbiter #(.RD_LATENCY(L0), .FAIR(1)) u0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));
  mem_arbiter #(.RD_LATENCY(L1), .FAIR(0)) u1 (
    .clk(clk), .reset(reset), .bus(bus1.slave));

  assign bus1.a_req   = bus0.a_req;
  assign bus1.b_req   = bus0.b_req;
  assign bus1.a_we    = bus0.a_we;
  assign bus1.b_we    = bus0.b_we;
  assign bus1.a_addr  = bus0.a_addr;
  assign bus1.b_addr  = bus0.b_addr;
  assign bus1.a_wdata = bus0.a_wdata;
  assign bus1.b_wdata = bus0.b_wdata;

  logic       o_aack [2];
  logic       o_back [2];
  logic       o_mw   [2];
  logic [7:0] o_ard  [2];
  logic [7:0] o_brd  [2];
  logic [7:0] o_addr [2];
  logic [7:0] o_wd   [2];

  assign o_aack[0] = bus0.a_ack;
  assign o_aack[1] = bus1.a_ack;
  assign o_back[0] = bus0.b_ack;
  assign o_back[1] = bus1.b_ack;
  assign o_mw[0]   = bus0.mem_write;
  assign o_mw[1]   = bus1.mem_write;
  assign o_ard[0]  = bus0.a_rdata;
  assign o_ard[1]  = bus1.a_rdata;
  assign o_brd[0]  = bus0.b_rdata;
  assign o_brd[1]  = bus1.b_rdata;
  assign o_addr[0] = bus0.mem_address;
  assign o_addr[1] = bus1.mem_address;
  assign o_wd[0]   = bus0.mem_data_in;
  assign o_wd[1]   = bus1.mem_data_in;

  function automatic logic [7:0] init_byte(input int i);
    logic [7:0] v;
    v = 8'(i);
    if (v == 8'hF2) return 8'hA7;
    return v ^ 8'h5A;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? L0 : L1;
  endfunction

  function automatic bit fair_of(input int k);
    return (k == 0);
  endfunction

  // External memory: ROM below ROM_TOP, read pipeline of RD_LATENCY stages
  logic [7:0] ext  [2][256];
  logic [7:0] pipe [2][3];

  assign bus0.mem_data_out = pipe[0][L0-1];
  assign bus1.mem_data_out = pipe[1][L1-1];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        for (int i = 0; i < 256; i++) ext[k][i] <= init_byte(i);
      end else if (o_mw[k] && (o_addr[k] >= ROM_TOP)) begin
        ext[k][o_addr[k]] <= o_wd[k];
      end
      pipe[k][0] <= ext[k][o_addr[k]];
      pipe[k][1] <= pipe[k][0];
      pipe[k][2] <= pipe[k][1];
    end
  end

  // Reference model: edge counting from the sampling edge of each access
  int         cyc;
  int         free_at [2];
  int         ack_at  [2];
  logic       last_b  [2];
  logic       who_b   [2];
  logic       cur_we  [2];
  logic [7:0] rdval   [2];
  logic [7:0] ref_mem [2][256];
  logic       e_mw    [2];
  logic       e_aack  [2];
  logic       e_back  [2];
  logic [7:0] e_ard   [2];
  logic [7:0] e_brd   [2];
  logic [7:0] e_addr  [2];
  logic [7:0] e_wd    [2];
  logic       start   [2];
  logic       s_b     [2];
  logic       s_we    [2];
  logic [7:0] s_addr  [2];
  logic [7:0] s_wd    [2];

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      s_b[k] = bus0.b_req &&
               (!bus0.a_req || (fair_of(k) && !last_b[k]));
      start[k] = (bus0.a_req || bus0.b_req) &&
                 (cyc + 1 >= free_at[k]);
      s_we[k]   = s_b[k] ? bus0.b_we    : bus0.a_we;
      s_addr[k] = s_b[k] ? bus0.b_addr  : bus0.a_addr;
      s_wd[k]   = s_b[k] ? bus0.b_wdata : bus0.a_wdata;
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc <= 0;
      for (int k = 0; k < 2; k++) begin
        free_at[k] <= 0;
        ack_at[k]  <= -1;
        last_b[k]  <= 1'b1;
        who_b[k]   <= 1'b0;
        cur_we[k]  <= 1'b0;
        rdval[k]   <= 8'h00;
        e_mw[k]    <= 1'b0;
        e_aack[k]  <= 1'b0;
        e_back[k]  <= 1'b0;
        e_ard[k]   <= 8'h00;
        e_brd[k]   <= 8'h00;
        e_addr[k]  <= 8'h00;
        e_wd[k]    <= 8'h00;
        for (int i = 0; i < 256; i++) ref_mem[k][i] <= init_byte(i);
      end
    end else begin
      cyc <= cyc + 1;
      for (int k = 0; k < 2; k++) begin
        e_mw[k]   <= 1'b0;
        e_aack[k] <= 1'b0;
        e_back[k] <= 1'b0;
        if (cyc + 1 == ack_at[k]) begin
          if (who_b[k]) e_back[k] <= 1'b1;
          else          e_aack[k] <= 1'b1;
          if (!cur_we[k] && who_b[k])  e_brd[k] <= rdval[k];
          if (!cur_we[k] && !who_b[k]) e_ard[k] <= rdval[k];
        end
        if (start[k]) begin
          last_b[k] <= s_b[k];
          who_b[k]  <= s_b[k];
          cur_we[k] <= s_we[k];
          e_addr[k] <= s_addr[k];
          e_wd[k]   <= s_wd[k];
          if (s_we[k]) begin
            e_mw[k] <= 1'b1;
            if (s_addr[k] >= ROM_TOP)
              ref_mem[k][s_addr[k]] <= s_wd[k];
          end else begin
            rdval[k] <= ref_mem[k][s_addr[k]];
          end
          ack_at[k]  <= cyc + 2 + (s_we[k] ? 0 : lat_of(k));
          free_at[k] <= cyc + 4 + (s_we[k] ? 0 : lat_of(k));
        end
      end
    end
  end

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("a_ack%0d", k), 8'(o_aack[k]), 8'(e_aack[k]));
      check($sformatf("b_ack%0d", k), 8'(o_back[k]), 8'(e_back[k]));
      check($sformatf("mem_write%0d", k), 8'(o_mw[k]), 8'(e_mw[k]));
      check($sformatf("a_rdata%0d", k), o_ard[k], e_ard[k]);
      check($sformatf("b_rdata%0d", k), o_brd[k], e_brd[k]);
      check($sformatf("mem_address%0d", k), o_addr[k], e_addr[k]);
      check($sformatf("mem_data_in%0d", k), o_wd[k], e_wd[k]);
    end
  endtask

  task automatic idle(input int n);
    bus0.a_req = 1'b0;
    bus0.b_req = 1'b0;
    repeat (n) tick();
  endtask

  // Single access seen through u0; drop>0 releases req after that many ticks
  task automatic txn(input bit pb, input bit we,
                     input logic [7:0] addr, input logic [7:0] wd,
                     input int drop, output int lat,
                     output logic [7:0] rd, output int mw,
                     output int other);
    bit ok;
    ok = 0;
    mw = 0;
    other = 0;
    lat = 1;
    rd = 8'h00;
    if (pb) begin
      bus0.b_we = we; bus0.b_addr = addr; bus0.b_wdata = wd;
      bus0.b_req = 1'b1;
    end else begin
      bus0.a_we = we; bus0.a_addr = addr; bus0.a_wdata = wd;
      bus0.a_req = 1'b1;
    end
    for (int i = 1; i <= 20 && !ok; i++) begin
      tick();
      lat++;
      if (i == drop) begin
        bus0.a_req = 1'b0;
        bus0.b_req = 1'b0;
      end
      if (bus0.mem_write) mw++;
      if (pb ? bus0.a_ack : bus0.b_ack) other++;
      if (pb ? bus0.b_ack : bus0.a_ack) begin
        ok = 1;
        rd = pb ? bus0.b_rdata : bus0.a_rdata;
      end
    end
    if (!ok) check("ack_timeout", 8'h00, 8'h01);
    bus0.a_req = 1'b0;
    bus0.b_req = 1'b0;
  endtask

  initial begin
    int lat;
    int mw;
    int other;
    int n0;
    int n1;
    logic [7:0] rd;
    logic [3:0] seq0;
    logic [3:0] seq1;

    bus0.a_req = 0; bus0.b_req = 0;
    bus0.a_we = 0; bus0.b_we = 0;
    bus0.a_addr = 0; bus0.b_addr = 0;
    bus0.a_wdata = 0; bus0.b_wdata = 0;
    repeat (3) tick();
    reset = 1'b1;
    idle(2);

    txn(0, 1, 8'h85, 8'h3C, 0, lat, rd, mw, other);
    check("wr_lat", 8'(lat), 8'd3);
    check("wr_pulse", 8'(mw), 8'd1);
    idle(4);
    txn(0, 0, 8'h85, 8'h00, 0, lat, rd, mw, other);
    check("rd_lat", 8'(lat), 8'd4);
    check("rd_85", rd, 8'h3C);
    idle(5);

    txn(1, 0, 8'hF2, 8'h00, 0, lat, rd, mw, other);
    check("b_rd_lat", 8'(lat), 8'd4);
    check("b_rd_F2", rd, 8'hA7);
    check("b_rd_no_a_ack", 8'(other), 8'd0);
    idle(5);

    txn(0, 1, 8'h10, 8'hFF, 0, lat, rd, mw, other);
    check("rom_wr_lat", 8'(lat), 8'd3);
    check("rom_wr_pulse", 8'(mw), 8'd1);
    idle(4);
    txn(0, 0, 8'h10, 8'h00, 0, lat, rd, mw, other);
    check("rom_rd_10", rd, 8'h4A);
    idle(5);

    txn(0, 0, 8'hC3, 8'h00, 2, lat, rd, mw, other);
    check("drop_rd_C3", rd, 8'h99);
    tick();
    check("drop_ack_once", 8'(bus0.a_ack), 8'd0);
    idle(5);

    bus0.b_we = 1'b0; bus0.b_addr = 8'hF2;
    bus0.b_req = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    bus0.b_req = 1'b0;
    repeat (3) tick();
    check("rst_addr", bus0.mem_address, 8'h00);
    check("rst_brd", bus0.b_rdata, 8'h00);
    reset = 1'b1;
    idle(2);
    txn(0, 0, 8'hF2, 8'h00, 0, lat, rd, mw, other);
    check("post_rst_lat", 8'(lat), 8'd4);
    check("post_rst_rd", rd, 8'hA7);
    idle(6);

    reset = 1'b0;
    tick();
    reset = 1'b1;
    bus0.a_we = 1'b1; bus0.a_addr = 8'h50; bus0.a_wdata = 8'h11;
    bus0.b_we = 1'b1; bus0.b_addr = 8'h60; bus0.b_wdata = 8'h22;
    bus0.a_req = 1'b1;
    bus0.b_req = 1'b1;
    n0 = 0; n1 = 0; seq0 = '0; seq1 = '0;
    for (int i = 0; i < 60 && (n0 < 4 || n1 < 4); i++) begin
      tick();
      if (n0 < 4 && (bus0.a_ack || bus0.b_ack)) begin
        seq0[n0] = bus0.b_ack;
        n0++;
      end
      if (n1 < 4 && (bus1.a_ack || bus1.b_ack)) begin
        seq1[n1] = bus1.b_ack;
        n1++;
      end
    end
    check("rr_count", 8'(n0), 8'd4);
    check("rr_seq", 8'(seq0), 8'b0000_1010);
    check("fixed_count", 8'(n1), 8'd4);
    check("fixed_seq", 8'(seq1), 8'b0000_0000);
    idle(8);

    for (int i = 0; i < 1500; i++) begin
      bus0.a_req   = ($urandom_range(0, 3) != 0);
      bus0.b_req   = ($urandom_range(0, 2) != 0);
      bus0.a_we    = 1'($urandom_range(0, 1));
      bus0.b_we    = 1'($urandom_range(0, 1));
      bus0.a_addr  = 8'($urandom);
      bus0.b_addr  = 8'($urandom);
      bus0.a_wdata = 8'($urandom);
      bus0.b_wdata = 8'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
      end
      tick();
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
